div_seq: RTL and testbench

Multicycle divide sequencer for the execute stage. It accepts a DIV/DIVU request from the pipeline and holds the pipeline stalled while a 32-step radix-2 restoring divide runs. It then presents the quotient (LO) and remainder (HI) with a one-cycle completion pulse for the HI/LO write. An exception flush can cancel it at any point.

---
 rtl/div_seq.sv | 150 +++++++++++++++
 tb/tb_div_seq.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/div_seq.sv
// div_seq: multicycle radix-2 restoring divider for the execute stage.
// Accepts a DIV/DIVU request, stalls the pipeline for 32 steps, and then
// presents the quotient on lo and the remainder on hi with a one-cycle
// result_valid pulse. A flush cancels the operation in any state.
//
// Ports:
//   clk, resetn   clock, asynchronous active-low reset
//   div_valid     divide request, held while the instruction waits in execute
//   div_sign      1 = signed DIV, 0 = DIVU
//   a, b          dividend / divisor, sampled in IDLE on start
//   flush         exception/ERET flush
//   stall_div     pipeline stall request (combinational)
//   result_valid  completion pulse, HI/LO write enable
//   lo, hi        quotient / remainder (registered)
module div_seq (
    input  logic        clk,
    input  logic        resetn,
    input  logic        div_valid,
    input  logic        div_sign,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        flush,
    output logic        stall_div,
    output logic        result_valid,
    output logic [31:0] lo,
    output logic [31:0] hi
);

    localparam int unsigned W  = 32;
    localparam int unsigned CW = 6;

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_DONE
    } state_t;

    state_t          state, state_n;
    logic [CW-1:0]   cnt, cnt_n;
    logic [W:0]      rem, rem_n;
    logic [W-1:0]    quo, quo_n;
    logic [W-1:0]    dv, dv_n;
    logic            neg_q, neg_q_n;
    logic            neg_r, neg_r_n;
    logic [W-1:0]    lo_n, hi_n;

    // Step datapath: shifted partial remainder and trial subtraction.
    // One extra bit on the difference gives a clean borrow/sign.
    logic [W+1:0]    shifted;
    logic [W+1:0]    diff;
    logic [W:0]      rem_step;
    logic [W-1:0]    quo_step;
    logic [W-1:0]    a_mag, b_mag;

    // State and datapath registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= S_IDLE;
            cnt   <= '0;
            rem   <= '0;
            quo   <= '0;
            dv    <= '0;
            neg_q <= 1'b0;
            neg_r <= 1'b0;
            lo    <= '0;
            hi    <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            rem   <= rem_n;
            quo   <= quo_n;
            dv    <= dv_n;
            neg_q <= neg_q_n;
            neg_r <= neg_r_n;
            lo    <= lo_n;
            hi    <= hi_n;
        end
    end

    // Next-state, datapath update and outputs.
    always_comb begin
        state_n      = state;
        cnt_n        = cnt;
        rem_n        = rem;
        quo_n        = quo;
        dv_n         = dv;
        neg_q_n      = neg_q;
        neg_r_n      = neg_r;
        lo_n         = lo;
        hi_n         = hi;
        stall_div    = 1'b0;
        result_valid = 1'b0;

        shifted  = {rem, quo[W-1]};
        diff     = shifted - {2'b00, dv};
        rem_step = diff[W+1] ? shifted[W:0] : diff[W:0];
        quo_step = {quo[W-2:0], ~diff[W+1]};

        // 0x80000000 negates to itself, which is the desired unsigned magnitude.
        a_mag = (div_sign && a[W-1]) ? (~a + W'(1)) : a;
        b_mag = (div_sign && b[W-1]) ? (~b + W'(1)) : b;

        unique case (state)
            S_IDLE: begin
                stall_div = div_valid;
                if (div_valid) begin
                    rem_n   = '0;
                    quo_n   = a_mag;
                    dv_n    = b_mag;
                    cnt_n   = '0;
                    neg_q_n = div_sign & (a[W-1] ^ b[W-1]);
                    neg_r_n = div_sign & a[W-1];
                    if (b == '0) begin
                        lo_n    = '1;
                        hi_n    = a;
                        state_n = S_DONE;
                    end else begin
                        state_n = S_BUSY;
                    end
                end
            end
            S_BUSY: begin
                stall_div = 1'b1;
                rem_n     = rem_step;
                quo_n     = quo_step;
                cnt_n     = cnt + CW'(1);
                if (cnt == CW'(W - 1)) begin
                    lo_n    = neg_q ? (~quo_step + W'(1)) : quo_step;
                    hi_n    = neg_r ? (~rem_step[W-1:0] + W'(1)) : rem_step[W-1:0];
                    state_n = S_DONE;
                end
            end
            S_DONE: begin
                result_valid = 1'b1;
                state_n      = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase

        // Flush cancels everything: no stall, no pulse, no HI/LO update.
        if (flush) begin
            state_n      = S_IDLE;
            lo_n         = lo;
            hi_n         = hi;
            stall_div    = 1'b0;
            result_valid = 1'b0;
        end
    end

endmodule

// File: tb/tb_div_seq.sv
// Self-checking bench for div_seq: directed cases plus randomized divides,
// compared each cycle against a transaction-level reference model.
module tb_div_seq;

    logic        clk;
    logic        resetn;
    logic        div_valid;
    logic        div_sign;
    logic [31:0] a;
    logic [31:0] b;
    logic        flush;
    logic        stall_div;
    logic        result_valid;
    logic [31:0] lo;
    logic [31:0] hi;

    int checks = 0;
    int errors = 0;

    div_seq dut (
        .clk          (clk),
        .resetn       (resetn),
        .div_valid    (div_valid),
        .div_sign     (div_sign),
        .a            (a),
        .b            (b),
        .flush        (flush),
        .stall_div    (stall_div),
        .result_valid (result_valid),
        .lo           (lo),
        .hi           (hi)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void check(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endfunction

    // Reference divide from the MIPS rules using plain arithmetic.
    function automatic void ref_div(input logic s, input logic [31:0] x, input logic [31:0] y,
                                    output logic [31:0] q_o, output logic [31:0] r_o);
        logic [31:0] xm, ym, q, r;
        if (y == 32'd0) begin
            q_o = 32'hFFFFFFFF;
            r_o = x;
        end else begin
            xm  = (s && x[31]) ? 32'd0 - x : x;
            ym  = (s && y[31]) ? 32'd0 - y : y;
            q   = xm / ym;
            r   = xm % ym;
            q_o = (s && (x[31] ^ y[31])) ? 32'd0 - q : q;
            r_o = (s && x[31]) ? 32'd0 - r : r;
        end
    endfunction

    // Transaction-level model: 0 idle, 1 busy, 2 result cycle.
    int          m_phase = 0;
    int          m_left  = 0;
    logic [31:0] m_lo = 32'd0, m_hi = 32'd0;
    logic [31:0] m_plo, m_phi;
    logic        e_stall, e_rv;

    always @(negedge clk) begin
        if (!resetn) begin
            m_phase = 0;
            m_lo    = 32'd0;
            m_hi    = 32'd0;
        end
        e_stall = !flush && ((m_phase == 0 && div_valid) || m_phase == 1);
        e_rv    = !flush && (m_phase == 2);
        check("stall_div", 32'(stall_div), 32'(e_stall));
        check("result_valid", 32'(result_valid), 32'(e_rv));
        check("lo", lo, m_lo);
        check("hi", hi, m_hi);
        if (!resetn || flush) begin
            m_phase = 0;
        end else begin
            case (m_phase)
                0: if (div_valid) begin
                    ref_div(div_sign, a, b, m_plo, m_phi);
                    if (b == 32'd0) begin
                        m_lo    = m_plo;
                        m_hi    = m_phi;
                        m_phase = 2;
                    end else begin
                        m_left  = 32;
                        m_phase = 1;
                    end
                end
                1: begin
                    m_left--;
                    if (m_left == 0) begin
                        m_lo    = m_plo;
                        m_hi    = m_phi;
                        m_phase = 2;
                    end
                end
                default: m_phase = 0;
            endcase
        end
    end

    // Issue one divide, wait (bounded) for the pulse, check latency and result.
    task automatic run_div(input logic s, input logic [31:0] x, input logic [31:0] y,
                           input logic [31:0] exp_lo, input logic [31:0] exp_hi, input int exp_lat);
        int lat;
        int stalls;
        lat    = -1;
        stalls = 0;
        @(posedge clk); #1;
        div_valid = 1'b1;
        div_sign  = s;
        a         = x;
        b         = y;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (result_valid) begin
                lat = c;
                break;
            end
            if (stall_div) stalls++;
        end
        check("latency", 32'(lat), 32'(exp_lat));
        check("stall_cycles", 32'(stalls), 32'(exp_lat));
        check("result_lo", lo, exp_lo);
        check("result_hi", hi, exp_hi);
        @(posedge clk); #1;
        div_valid = 1'b0;
    endtask

    // Start a divide and flush it during busy cycle k.
    task automatic flush_div(input logic s, input logic [31:0] x, input logic [31:0] y, input int k);
        @(posedge clk); #1;
        div_valid = 1'b1;
        div_sign  = s;
        a         = x;
        b         = y;
        repeat (k) @(posedge clk);
        #1 flush = 1'b1;
        @(negedge clk);
        check("stall_on_flush", 32'(stall_div), 32'd0);
        @(posedge clk); #1;
        flush     = 1'b0;
        div_valid = 1'b0;
    endtask

    logic [31:0] rq, rr, ra, rb;
    logic        rs;
    int          rv_seen;

    initial begin
        resetn    = 1'b0;
        div_valid = 1'b0;
        div_sign  = 1'b0;
        a         = 32'd0;
        b         = 32'd0;
        flush     = 1'b0;

        // Pin the reference model with hand-computed values.
        ref_div(1'b0, 32'd100, 32'd7, rq, rr);
        check("model_100_7_q", rq, 32'd14);
        check("model_100_7_r", rr, 32'd2);
        ref_div(1'b1, 32'hFFFFFFF9, 32'd2, rq, rr);
        check("model_m7_2_q", rq, 32'hFFFFFFFD);
        check("model_m7_2_r", rr, 32'hFFFFFFFF);
        ref_div(1'b1, 32'h80000000, 32'hFFFFFFFF, rq, rr);
        check("model_ovf_q", rq, 32'h80000000);
        check("model_ovf_r", rr, 32'd0);

        repeat (3) @(posedge clk);
        #1 resetn = 1'b1;
        @(negedge clk);
        check("reset_stall", 32'(stall_div), 32'd0);
        check("reset_rv", 32'(result_valid), 32'd0);
        check("reset_lo", lo, 32'd0);
        check("reset_hi", hi, 32'd0);

        run_div(1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 33);
        run_div(1'b1, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 32'hFFFFFFFF, 33);
        run_div(1'b0, 32'hFFFFFFF9, 32'd2, 32'h7FFFFFFC, 32'd1, 33);
        run_div(1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'd0, 33);
        run_div(1'b1, 32'd7, 32'hFFFFFFFE, 32'hFFFFFFFD, 32'd1, 33);
        run_div(1'b0, 32'h12345678, 32'd0, 32'hFFFFFFFF, 32'h12345678, 1);

        // Flush at cycle 10: no pulse, HI/LO keep the divide-by-zero result.
        flush_div(1'b0, 32'd100, 32'd7, 10);
        rv_seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (result_valid) rv_seen++;
        end
        check("flush_no_rv", 32'(rv_seen), 32'd0);
        check("flush_lo_kept", lo, 32'hFFFFFFFF);
        check("flush_hi_kept", hi, 32'h12345678);
        run_div(1'b0, 32'd9, 32'd4, 32'd2, 32'd1, 33);

        // Flush together with a request in IDLE: no start.
        @(posedge clk); #1;
        div_valid = 1'b1;
        a         = 32'd50;
        b         = 32'd3;
        flush     = 1'b1;
        @(negedge clk);
        check("idle_flush_stall", 32'(stall_div), 32'd0);
        @(posedge clk); #1;
        div_valid = 1'b0;
        flush     = 1'b0;
        @(negedge clk);
        check("idle_flush_nostart", 32'(stall_div), 32'd0);

        // Asynchronous reset in the middle of a divide.
        @(posedge clk); #1;
        div_valid = 1'b1;
        div_sign  = 1'b0;
        a         = 32'd100;
        b         = 32'd7;
        repeat (15) @(posedge clk);
        #3;
        resetn    = 1'b0;
        div_valid = 1'b0;
        #1;
        check("arst_stall", 32'(stall_div), 32'd0);
        check("arst_rv", 32'(result_valid), 32'd0);
        check("arst_lo", lo, 32'd0);
        check("arst_hi", hi, 32'd0);
        @(posedge clk); #1 resetn = 1'b1;
        run_div(1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 33);

        // Randomized divides with corner operands and occasional flushes.
        for (int i = 0; i < 40; i++) begin
            rs = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 5))
                0:       ra = 32'h80000000;
                1:       ra = 32'd0;
                2:       ra = 32'hFFFFFFFF;
                default: ra = $urandom;
            endcase
            case ($urandom_range(0, 6))
                0:       rb = 32'd0;
                1:       rb = 32'd1;
                2:       rb = 32'hFFFFFFFF;
                3:       rb = 32'($urandom_range(1, 15));
                default: rb = $urandom;
            endcase
            if ((i % 5) == 4 && rb != 32'd0) begin
                flush_div(rs, ra, rb, int'($urandom_range(1, 32)));
            end else begin
                ref_div(rs, ra, rb, rq, rr);
                run_div(rs, ra, rb, rq, rr, (rb == 32'd0) ? 1 : 33);
            end
            repeat ($urandom_range(0, 2)) @(posedge clk);
        end

        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
